// File: rtl/game_tick_if.sv
// Handshake and status bundle between the snake game logic and the step scheduler.
interface game_tick_if;
    logic       start;
    logic       pause;
    logic       game_over;
    logic       eat;
    logic       tick_ack;
    logic       tick;
    logic       overrun;
    logic [3:0] level;
    logic [1:0] state;

    // Game-logic side: issues control pulses, consumes step requests.
    modport master (
        output start, pause, game_over, eat, tick_ack,
        input  tick, overrun, level, state
    );

    // Scheduler side.
    modport slave (
        input  start, pause, game_over, eat, tick_ack,
        output tick, overrun, level, state
    );
endinterface

// File: rtl/game_tick_scheduler.sv
// Game-step scheduler: issues one held tick request per game step, shortening the
// step period as the snake eats, and sequences start/pause/game-over.
module game_tick_scheduler #(
    parameter int unsigned BASE_PERIOD     = 10000000,
    parameter int unsigned STEP            = 1000000,
    parameter int unsigned MAX_LEVEL       = 9,
    parameter int unsigned FOODS_PER_LEVEL = 4,
    parameter int unsigned CNT_W           = 25
) (
    input  logic         clkin,
    input  logic         resetn,
    game_tick_if.slave   bus
);

    localparam int unsigned LVL_W  = 4;
    localparam int unsigned FOOD_W = (FOODS_PER_LEVEL > 1) ? $clog2(FOODS_PER_LEVEL) : 1;

    localparam logic [CNT_W-1:0]  BASE_CNT  = CNT_W'(BASE_PERIOD);
    localparam logic [CNT_W-1:0]  STEP_CNT  = CNT_W'(STEP);
    localparam logic [LVL_W-1:0]  LVL_MAX   = LVL_W'(MAX_LEVEL);
    localparam logic [FOOD_W-1:0] FOOD_LAST = FOOD_W'(FOODS_PER_LEVEL - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10,
        ST_OVER   = 2'b11
    } state_e;

    state_e              state_q,   state_d;
    logic [CNT_W-1:0]    count_q,   count_d;
    logic [CNT_W-1:0]    period_q,  period_d;
    logic [LVL_W-1:0]    level_q,   level_d;
    logic [FOOD_W-1:0]   food_q,    food_d;
    logic                tick_q,    tick_d;
    logic                overrun_q, overrun_d;

    logic advance;
    logic eat_ok;
    logic terminal;

    // Next-state: FSM sequencing, step counter, tick handshake and speed levels.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        period_d  = period_q;
        level_d   = level_q;
        food_d    = food_q;
        tick_d    = tick_q;
        overrun_d = overrun_q;
        advance   = 1'b0;
        eat_ok    = 1'b0;
        terminal  = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (bus.start && !bus.game_over) begin
                    state_d   = ST_RUN;
                    count_d   = '0;
                    period_d  = BASE_CNT;
                    level_d   = '0;
                    food_d    = '0;
                    tick_d    = 1'b0;
                    overrun_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (bus.game_over) begin
                    state_d = ST_OVER;
                    tick_d  = 1'b0;
                end else begin
                    eat_ok = bus.eat;
                    if (bus.tick_ack) tick_d = 1'b0;
                    if (bus.pause) state_d = ST_PAUSED;
                    else           advance = 1'b1;
                end
            end
            ST_PAUSED: begin
                if (bus.game_over) begin
                    state_d = ST_OVER;
                    tick_d  = 1'b0;
                end else begin
                    if (bus.tick_ack) tick_d = 1'b0;
                    if (!bus.pause)   state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A terminal event re-requests the step; an unacked pending request flags overrun.
        if (advance) begin
            terminal = (count_q == period_q - CNT_W'(1));
            if (terminal) begin
                count_d  = '0;
                period_d = BASE_CNT - CNT_W'(level_q) * STEP_CNT;
                tick_d   = 1'b1;
                if (tick_q && !bus.tick_ack) overrun_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end

        if (eat_ok) begin
            if (food_q == FOOD_LAST) begin
                food_d = '0;
                if (level_q < LVL_MAX) level_d = level_q + LVL_W'(1);
            end else begin
                food_d = food_q + FOOD_W'(1);
            end
        end
    end

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            period_q  <= BASE_CNT;
            level_q   <= '0;
            food_q    <= '0;
            tick_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            period_q  <= period_d;
            level_q   <= level_d;
            food_q    <= food_d;
            tick_q    <= tick_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.tick    = tick_q;
    assign bus.overrun = overrun_q;
    assign bus.level   = level_q;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed plus randomized bench for game_tick_scheduler against a countdown-based reference model.
module tb_game_tick_scheduler;

    localparam int unsigned BP  = 10;
    localparam int unsigned ST  = 2;
    localparam int unsigned ML  = 3;
    localparam int unsigned FPL = 2;
    localparam int unsigned CW  = 4;

    logic clkin = 1'b0;
    logic resetn;
    always #5 clkin = ~clkin;

    game_tick_if bus ();

    game_tick_scheduler #(
        .BASE_PERIOD     (BP),
        .STEP            (ST),
        .MAX_LEVEL       (ML),
        .FOODS_PER_LEVEL (FPL),
        .CNT_W           (CW)
    ) dut (
        .clkin  (clkin),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    // Reference model: state code, cycles left in current step, eats since game start.
    int m_state;
    int m_left;
    int m_eats;
    bit m_tick;
    bit m_ovr;

    function automatic int m_level();
        int l;
        l = m_eats / FPL;
        if (l > int'(ML)) l = ML;
        return l;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_state"},   8'(bus.state),   8'(m_state));
        chk({tag, "_level"},   8'(bus.level),   8'(m_level()));
        chk({tag, "_tick"},    8'(bus.tick),    8'(m_tick));
        chk({tag, "_overrun"}, 8'(bus.overrun), 8'(m_ovr));
    endtask

    task automatic model_reset();
        m_state = 0;
        m_left  = BP;
        m_eats  = 0;
        m_tick  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic model_edge(input bit s, input bit p, input bit g, input bit e, input bit a);
        int lvl_before;
        case (m_state)
            0, 3: begin
                if (s && !g) begin
                    m_state = 1;
                    m_left  = BP;
                    m_eats  = 0;
                    m_tick  = 1'b0;
                    m_ovr   = 1'b0;
                end
            end
            1: begin
                if (g) begin
                    m_state = 3;
                    m_tick  = 1'b0;
                end else begin
                    lvl_before = m_level();
                    if (e) m_eats++;
                    if (p) begin
                        m_state = 2;
                        if (a) m_tick = 1'b0;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            if (m_tick && !a) m_ovr = 1'b1;
                            m_tick = 1'b1;
                            m_left = BP - lvl_before * ST;
                        end else if (a) begin
                            m_tick = 1'b0;
                        end
                    end
                end
            end
            default: begin
                if (g) begin
                    m_state = 3;
                    m_tick  = 1'b0;
                end else begin
                    if (a) m_tick = 1'b0;
                    if (!p) m_state = 1;
                end
            end
        endcase
    endtask

    task automatic step(input bit s, input bit p, input bit g, input bit e, input bit a);
        bus.start     = s;
        bus.pause     = p;
        bus.game_over = g;
        bus.eat       = e;
        bus.tick_ack  = a;
        model_edge(s, p, g, e, a);
        @(posedge clkin);
        #1;
        edge_cnt++;
        check_all("cyc");
    endtask

    // Steps idle until tick rises; bounded so a stuck design still reaches the summary.
    task automatic wait_rise(output int at);
        int n;
        n = 0;
        while (bus.tick !== 1'b1 && n < 40) begin
            step(0, 0, 0, 0, 0);
            n++;
        end
        chk("rise_seen", 8'(bus.tick), 8'd1);
        at = edge_cnt;
    endtask

    int  s0, r1, r2, r3, r4, r5, r6, r7, r8, rel, rp;
    bit  p_lvl;

    initial begin
        bus.start = 0; bus.pause = 0; bus.game_over = 0; bus.eat = 0; bus.tick_ack = 0;
        resetn = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        resetn = 1'b1;

        // Start, first-tick latency and steady step spacing.
        step(1, 0, 0, 0, 0);
        s0 = edge_cnt;
        chk("start_state", 8'(bus.state), 8'd1);
        wait_rise(r1);
        chk("first_tick_gap", 8'(r1 - s0), 8'd10);
        step(0, 0, 0, 0, 1);
        chk("ack_clears", 8'(bus.tick), 8'd0);
        wait_rise(r2);
        chk("gap_l0", 8'(r2 - r1), 8'd10);

        // Level-up mid-step applies from the following step.
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("level1", 8'(bus.level), 8'd1);
        wait_rise(r3);
        chk("gap_cur_step", 8'(r3 - r2), 8'd10);
        step(0, 0, 0, 0, 1);
        wait_rise(r4);
        chk("gap_l1_a", 8'(r4 - r3), 8'd8);
        step(0, 0, 0, 0, 1);
        wait_rise(r5);
        chk("gap_l1_b", 8'(r5 - r4), 8'd8);

        // Saturation at MAX_LEVEL.
        step(0, 0, 0, 0, 1);
        repeat (6) step(0, 0, 0, 1, 0);
        chk("level_sat", 8'(bus.level), 8'd3);
        wait_rise(r6);
        chk("gap_before_sat", 8'(r6 - r5), 8'd8);
        step(0, 0, 0, 0, 1);
        wait_rise(r7);
        chk("gap_sat_a", 8'(r7 - r6), 8'd4);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("level_held_max", 8'(bus.level), 8'd3);
        wait_rise(r8);
        chk("gap_sat_b", 8'(r8 - r7), 8'd4);

        // Withheld ack -> overrun; game over keeps level/overrun; restart clears them.
        repeat (3) step(0, 0, 0, 0, 0);
        chk("no_overrun_yet", 8'(bus.overrun), 8'd0);
        step(0, 0, 0, 0, 0);
        chk("overrun_set", 8'(bus.overrun), 8'd1);
        chk("tick_held", 8'(bus.tick), 8'd1);
        step(0, 0, 1, 0, 0);
        chk("over_state", 8'(bus.state), 8'd3);
        chk("over_tick", 8'(bus.tick), 8'd0);
        chk("over_overrun", 8'(bus.overrun), 8'd1);
        step(0, 1, 0, 1, 1);
        chk("over_ignores", 8'(bus.level), 8'd3);
        step(1, 0, 0, 0, 0);
        chk("restart_state", 8'(bus.state), 8'd1);
        chk("restart_overrun", 8'(bus.overrun), 8'd0);
        chk("restart_level", 8'(bus.level), 8'd0);

        // Pause at count 5 for 20 cycles, then 5 running cycles to the tick.
        repeat (5) step(0, 0, 0, 0, 0);
        repeat (20) step(0, 1, 0, 0, 0);
        chk("paused_state", 8'(bus.state), 8'd2);
        chk("paused_no_tick", 8'(bus.tick), 8'd0);
        step(0, 0, 0, 0, 0);
        rel = edge_cnt;
        chk("resume_state", 8'(bus.state), 8'd1);
        wait_rise(rp);
        chk("resume_gap", 8'(rp - rel), 8'd5);

        // Async reset between edges, start ignored while held in reset.
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        #3;
        resetn = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        bus.start = 1'b1;
        @(posedge clkin);
        #1;
        bus.start = 1'b0;
        check_all("rst_start");
        #2;
        resetn = 1'b1;
        step(1, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("go_beats_pause", 8'(bus.state), 8'd3);

        // Randomized traffic checked every cycle against the model.
        p_lvl = 1'b0;
        for (int i = 0; i < 600; i++) begin
            bit s, g, e, a;
            if ($urandom_range(0, 99) < 8) p_lvl = ~p_lvl;
            s = ($urandom_range(0, 99) < 10);
            g = ($urandom_range(0, 99) < 2);
            e = ($urandom_range(0, 99) < 20);
            a = ($urandom_range(0, 99) < 40);
            step(s, p_lvl, g, e, a);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
